// File: rtl/pll_lock_sequencer.sv
// Reference-clock sequencer for the fabric PLL: pulses its reset, qualifies
// lock, releases the system reset, retries on timeout and latches a fault.
module pll_lock_sequencer #(
  parameter int unsigned RST_PULSE_CYCLES    = 64,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 50000,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned MAX_RETRIES         = 7,
  parameter int unsigned CNT_W               = 16
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       restart,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       ready,
  output logic       fault,
  output logic       lock_lost,
  output logic [2:0] retry_count
);

  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] ST_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [2:0]       MAX_R    = 3'(MAX_RETRIES);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  typedef enum logic [2:0] {
    S_RESET_PLL,
    S_WAIT_LOCK,
    S_STABLE,
    S_RUN,
    S_FAULT
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       sync_q;
  logic             locked_s;
  logic             pll_rst_q;
  logic             sys_rst_q;
  logic             ready_q;
  logic             fault_q;
  logic             lost_q;
  logic [2:0]       retry_q;

  // pll_locked is asynchronous to refclk
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], pll_locked};
    end
  end

  assign locked_s = sync_q[1];

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_q   <= S_RESET_PLL;
      cnt_q     <= '0;
      pll_rst_q <= 1'b1;
      sys_rst_q <= 1'b1;
      ready_q   <= 1'b0;
      fault_q   <= 1'b0;
      lost_q    <= 1'b0;
      retry_q   <= 3'd0;
    end else begin
      lost_q <= 1'b0;
      if (restart) begin
        state_q   <= S_RESET_PLL;
        cnt_q     <= '0;
        retry_q   <= 3'd0;
        pll_rst_q <= 1'b1;
        sys_rst_q <= 1'b1;
        ready_q   <= 1'b0;
        fault_q   <= 1'b0;
      end else begin
        unique case (state_q)
          S_RESET_PLL: begin
            if (cnt_q == RST_LAST) begin
              state_q   <= S_WAIT_LOCK;
              cnt_q     <= '0;
              pll_rst_q <= 1'b0;
            end else begin
              cnt_q <= cnt_q + ONE;
            end
          end
          S_WAIT_LOCK: begin
            if (locked_s) begin
              state_q <= S_STABLE;
              cnt_q   <= '0;
            end else if (cnt_q == TO_LAST) begin
              cnt_q     <= '0;
              pll_rst_q <= 1'b1;
              if (retry_q == MAX_R) begin
                state_q <= S_FAULT;
                fault_q <= 1'b1;
              end else begin
                state_q <= S_RESET_PLL;
                retry_q <= retry_q + 3'd1;
              end
            end else begin
              cnt_q <= cnt_q + ONE;
            end
          end
          S_STABLE: begin
            if (!locked_s) begin
              state_q <= S_WAIT_LOCK;
              cnt_q   <= '0;
            end else if (cnt_q == ST_LAST) begin
              state_q   <= S_RUN;
              cnt_q     <= '0;
              sys_rst_q <= 1'b0;
              ready_q   <= 1'b1;
            end else begin
              cnt_q <= cnt_q + ONE;
            end
          end
          S_RUN: begin
            // Lock loss restarts the whole sequence with a fresh retry budget
            if (!locked_s) begin
              state_q   <= S_RESET_PLL;
              cnt_q     <= '0;
              retry_q   <= 3'd0;
              lost_q    <= 1'b1;
              pll_rst_q <= 1'b1;
              sys_rst_q <= 1'b1;
              ready_q   <= 1'b0;
            end
          end
          S_FAULT: begin
          end
          default: begin
            state_q   <= S_RESET_PLL;
            cnt_q     <= '0;
            pll_rst_q <= 1'b1;
            sys_rst_q <= 1'b1;
            ready_q   <= 1'b0;
            fault_q   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign pll_rst     = pll_rst_q;
  assign sys_rst     = sys_rst_q;
  assign ready       = ready_q;
  assign fault       = fault_q;
  assign lock_lost   = lost_q;
  assign retry_count = retry_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Bench for pll_lock_sequencer: phase/age reference model compared every
// cycle, directed literal scenarios, then randomized lock/restart/reset.
module tb_pll_lock_sequencer;

  localparam int RSTP = 4;
  localparam int TO   = 20;
  localparam int ST   = 8;
  localparam int MAXR = 2;

  localparam int PH_RST  = 0;
  localparam int PH_WAIT = 1;
  localparam int PH_STAB = 2;
  localparam int PH_RUN  = 3;
  localparam int PH_FLT  = 4;

  localparam int W_PRST  = 0;
  localparam int W_READY = 1;
  localparam int W_FAULT = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pll_locked = 1'b0;
  logic       restart = 1'b0;
  logic       pll_rst;
  logic       sys_rst;
  logic       ready;
  logic       fault;
  logic       lock_lost;
  logic [2:0] retry_count;

  int ntests = 0;
  int nfail  = 0;

  pll_lock_sequencer #(
    .RST_PULSE_CYCLES   (RSTP),
    .LOCK_TIMEOUT_CYCLES(TO),
    .LOCK_STABLE_CYCLES (ST),
    .MAX_RETRIES        (MAXR),
    .CNT_W              (16)
  ) dut (
    .refclk     (clk),
    .rst        (rst),
    .pll_locked (pll_locked),
    .restart    (restart),
    .pll_rst    (pll_rst),
    .sys_rst    (sys_rst),
    .ready      (ready),
    .fault      (fault),
    .lock_lost  (lock_lost),
    .retry_count(retry_count)
  );

  always #10 clk = ~clk;

  // Reference model: phase, edge timestamp of phase entry, and a two-deep
  // queue of past pll_locked samples standing in for the synchroniser.
  int m_ph    = PH_RST;
  int m_t0    = 0;
  int m_cyc   = 0;
  int m_retry = 0;
  bit m_lost  = 1'b0;
  bit lk_q[$] = '{1'b0, 1'b0};
  bit m_ls;
  int m_age;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ph = PH_RST; m_t0 = 0; m_cyc = 0;
      m_retry = 0; m_lost = 1'b0;
      lk_q = '{1'b0, 1'b0};
    end else begin
      m_ls = lk_q.pop_front();
      lk_q.push_back(pll_locked);
      m_cyc++;
      m_age = m_cyc - m_t0;
      m_lost = 1'b0;
      if (restart) begin
        m_ph = PH_RST; m_t0 = m_cyc; m_retry = 0;
      end else begin
        case (m_ph)
          PH_RST:
            if (m_age == RSTP) begin m_ph = PH_WAIT; m_t0 = m_cyc; end
          PH_WAIT:
            if (m_ls) begin
              m_ph = PH_STAB; m_t0 = m_cyc;
            end else if (m_age == TO) begin
              m_t0 = m_cyc;
              if (m_retry == MAXR) m_ph = PH_FLT;
              else begin m_retry++; m_ph = PH_RST; end
            end
          PH_STAB:
            if (!m_ls) begin m_ph = PH_WAIT; m_t0 = m_cyc; end
            else if (m_age == ST) begin m_ph = PH_RUN; m_t0 = m_cyc; end
          PH_RUN:
            if (!m_ls) begin
              m_lost = 1'b1; m_retry = 0;
              m_ph = PH_RST; m_t0 = m_cyc;
            end
          default: ;
        endcase
      end
    end
  end

  function automatic logic [7:0] exp_vec();
    return {(m_ph == PH_RST) || (m_ph == PH_FLT), m_ph != PH_RUN,
            m_ph == PH_RUN, m_ph == PH_FLT, m_lost, 3'(m_retry)};
  endfunction

  function automatic logic [7:0] dut_vec();
    return {pll_rst, sys_rst, ready, fault, lock_lost, retry_count};
  endfunction

  int ecyc = 0;
  always @(posedge clk or posedge rst) begin
    if (rst) ecyc <= 0;
    else ecyc <= ecyc + 1;
  end

  int prst_rise = 0;
  bit prst_prev = 1'b1;
  always @(posedge clk) begin
    #1;
    if (pll_rst && !prst_prev) prst_rise++;
    prst_prev = pll_rst;
  end

  task automatic chk(input string name, input int act, input int exp);
    ntests++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cmp_loop();
    forever begin
      @(negedge clk);
      ntests++;
      if (dut_vec() !== exp_vec()) begin
        nfail++;
        $display("FAIL model t=%0t: got %b, expected %b (prst,srst,rdy,flt,lost,retry)",
                 $time, dut_vec(), exp_vec());
      end
    end
  endtask

  function automatic logic sel(input int w);
    case (w)
      W_PRST:  return pll_rst;
      W_READY: return ready;
      W_FAULT: return fault;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_sig(input int w, input logic v, output int e);
    e = -1;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      if (sel(w) == v) begin
        e = ecyc;
        break;
      end
    end
  endtask

  task automatic to_edge(input int n);
    for (int i = 0; i < 400 && ecyc < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset(input logic lk, output int base);
    @(negedge clk);
    rst = 1'b1; pll_locked = lk; restart = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1 base = prst_rise;
  endtask

  int e;
  int base;
  int seg;
  bit lk;

  initial begin
    fork
      cmp_loop();
    join_none

    // 1: power-up, lock 10 cycles after pll_rst falls
    repeat (3) @(negedge clk);
    chk("reset_vec", int'(dut_vec()), 'hC0);
    rst = 1'b0;
    wait_sig(W_PRST, 1'b0, e);
    chk("t1_prst_fall_edge", e, 4);
    to_edge(14);
    @(negedge clk); pll_locked = 1'b1;
    wait_sig(W_READY, 1'b1, e);
    chk("t1_ready_edge", e, 25);
    chk("t1_sys_rst", int'(sys_rst), 0);
    chk("t1_retry", int'(retry_count), 0);

    // 4: lock loss while running
    to_edge(30);
    @(negedge clk); pll_locked = 1'b0; base = prst_rise;
    wait_sig(W_READY, 1'b0, e);
    chk("t4_ready_fall_edge", e, 33);
    chk("t4_lock_lost", int'(lock_lost), 1);
    chk("t4_sys_rst", int'(sys_rst), 1);
    chk("t4_pll_rst", int'(pll_rst), 1);
    @(negedge clk); pll_locked = 1'b1;
    to_edge(34);
    chk("t4_lost_one_cycle", int'(lock_lost), 0);
    wait_sig(W_PRST, 1'b0, e);
    chk("t4_prst_fall_edge", e, 37);
    wait_sig(W_READY, 1'b1, e);
    chk("t4_relock_edge", e, 46);
    @(negedge clk);
    chk("t4_prst_rises", prst_rise - base, 1);

    // 2: one-cycle glitch three cycles into STABLE
    do_reset(1'b1, base);
    to_edge(8);
    @(negedge clk); pll_locked = 1'b0;
    to_edge(9);
    @(negedge clk); pll_locked = 1'b1;
    wait_sig(W_READY, 1'b1, e);
    chk("t2_ready_edge", e, 20);
    chk("t2_retry", int'(retry_count), 0);
    @(negedge clk);
    chk("t2_prst_rises", prst_rise - base, 0);

    // 3: never locks -> two retries then FAULT
    do_reset(1'b0, base);
    to_edge(30);
    chk("t3_retry_1", int'(retry_count), 1);
    to_edge(50);
    chk("t3_retry_2", int'(retry_count), 2);
    wait_sig(W_FAULT, 1'b1, e);
    chk("t3_fault_edge", e, 72);
    chk("t3_fault_prst", int'(pll_rst), 1);
    @(negedge clk);
    chk("t3_prst_rises", prst_rise - base, 3);
    to_edge(82);
    chk("t3_fault_held", int'({fault, pll_rst, sys_rst}), 7);

    // 5: restart from FAULT, then restart colliding with a timeout
    @(negedge clk); restart = 1'b1;
    to_edge(83);
    chk("t5_fault_clr", int'(fault), 0);
    chk("t5_retry_clr", int'(retry_count), 0);
    chk("t5_prst", int'(pll_rst), 1);
    @(negedge clk); restart = 1'b0;
    wait_sig(W_PRST, 1'b0, e);
    chk("t5_prst_fall_edge", e, 87);
    to_edge(106);
    @(negedge clk); restart = 1'b1;
    to_edge(107);
    chk("t5_collide_retry", int'(retry_count), 0);
    chk("t5_collide_prst", int'(pll_rst), 1);
    @(negedge clk); restart = 1'b0;
    wait_sig(W_PRST, 1'b0, e);
    chk("t5_collide_fall_edge", e, 111);

    // 6: asynchronous reset in the middle of STABLE
    do_reset(1'b1, base);
    to_edge(7);
    @(negedge clk);
    #3 rst = 1'b1;
    #1;
    chk("t6_async_vec", int'({pll_rst, sys_rst, ready}), 6);
    chk("t6_async_ecyc", ecyc, 0);
    @(negedge clk); rst = 1'b0;
    wait_sig(W_PRST, 1'b0, e);
    chk("t6_prst_fall_edge", e, 4);
    wait_sig(W_READY, 1'b1, e);
    chk("t6_ready_edge", e, 13);

    // randomized lock segments, restarts and mid-cycle resets
    seg = 0;
    for (int c = 0; c < 5000; c++) begin
      @(negedge clk);
      if (seg == 0) begin
        lk  = ($urandom_range(0, 2) != 0);
        seg = $urandom_range(1, 90);
      end
      seg--;
      pll_locked = lk;
      restart = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 999) == 0) begin
        #3 rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; restart = 1'b0;
      end
    end
    @(negedge clk); restart = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
